demux4_5bits_fifo: RTL and testbench
====================================

Name: demux4_5bits_fifo

Overview:
- 1-to-4 registered distributor; the write-side counterpart of the 4-way 5-bit selector.
- Accepts one WIDTH-bit word per cycle with a 2-bit destination code and steers it into one of four per-channel FIFOs (A, B, C, D).
- Each channel drains independently over its own valid/ready handshake.
- Sits in front of the four consumers that the selector reads back from; uses the same select encoding: 00=A, 01=B, 10=C, 11=D.

Parameters:
- WIDTH, 5, data bits per word.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.
- CNTW, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  input word present.
- in_ready  output  1  the selected channel can accept a word.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel: 00=A, 01=B, 10=C, 11=D.
- out_valid  output  4  per-channel word available; bit0=A … bit3=D.
- out_ready  input  4  per-channel consumer ready.
- out_data  output  4*WIDTH  channel i head word at bits [i*WIDTH +: WIDTH].
- out_count  output  4*3  channel i occupancy (0..DEPTH) at bits [i*3 +: 3].
- accepted  output  CNTW  total words accepted since reset; wraps modulo 2^CNTW.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n, sampled on the clk rising edge.
- Reset (rst_n=0 at an edge):
  - All read/write pointers, occupancies and the accepted counter go to 0.
  - The next cycle shows out_valid=4'b0000, out_count=0, accepted=0, out_data all zeros.
  - FIFO storage is not cleared.
  - Reset mid-transfer discards every queued word. No handshake completes in a reset cycle.
- in_ready is combinational: in_ready = (occupancy[in_sel] != DEPTH). It depends only on registered state and in_sel, and never on in_valid or out_ready.
- Push: when in_valid && in_ready at an edge, in_data is written to channel in_sel's tail and accepted increments by 1 (2^CNTW-1 wraps to 0).
- Latency: a word pushed at edge N is visible at the channel head from edge N onward (out_valid high in cycle N+1) if that FIFO was empty. There is no combinational bypass from in_data to out_data.
- out_valid[i] = (occupancy[i] != 0), registered-state derived.
- out_data[i] is the head entry when out_valid[i]=1, and all zeros when the channel is empty.
- Pop: when out_valid[i] && out_ready[i] at an edge, the channel-i head advances. All four channels may pop in the same cycle.
- Push and pop on the same channel in the same edge:
  - Occupancy unchanged, both pointers advance.
  - When the channel is full, in_ready is 0 that cycle (no full-bypass); the push waits one cycle.
- Push to one channel while other channels pop: fully independent.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is held separately so full and empty are unambiguous.
- Order is preserved within a channel. No ordering guarantee across channels.
- in_valid with in_ready=0: no state change. The upstream source holds in_data and in_sel stable until accepted.
- in_sel may change between words freely; only its value at the accepting edge matters.
- out_ready asserted with out_valid=0 has no effect.
- X on in_valid is not tolerated; other inputs are don't-care while in_valid=0.

Test Plan:
- Reset, then push 8 to sel=00, 6 to 01, 4 to 10, 2 to 11, with out_ready=0 -> out_valid=1111; out_data A/B/C/D = 8/6/4/2; out_count=1 each; accepted=4.
- Push 3, 7, 9 to channel B with out_ready=0 -> in_ready=1, 1, then 0 for the third word while in_sel=01; B count=2; accepted=2. Raise out_ready[1] for one cycle -> B head 3 pops, 7 becomes head, count=1; the stalled 9 is accepted on the following edge.
- Channel C full with {1, 2}, out_ready[2]=1, and in_valid with in_sel=10, data 5 -> no push that cycle (in_ready=0), pop of 1; next edge accepts 5; drain yields 2 then 5.
- Empty channel D, push 17 with out_ready[3]=1 held -> out_valid[3] rises the cycle after the push edge, pops one edge later; out_data D returns to 0 and count to 0.
- Fill all channels to DEPTH, assert rst_n=0 for one edge -> out_valid=0000, counts 0, accepted=0. Push 12 to A -> A head 12, count 1, none of the stale words appear.
- Stream 260 words round-robin over sel 00..11 with out_ready=1111 -> accepted wraps to 4 (260 mod 256); per-channel output order matches input order; no word lost or duplicated.

Source files
------------

// File: rtl/demux4_5bits_fifo.sv
// demux4_5bits_fifo: steers each input word into one of four per-channel FIFOs, each drained by its own valid/ready handshake
module demux4_5bits_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [11:0]        out_count,
    output logic [CNTW-1:0]    accepted
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] FULL = 3'(DEPTH);
    logic [3:0] full;
    logic       push;
    assign in_ready = !full[in_sel];
    assign push = in_valid && in_ready;
    always_ff @(posedge clk)
        accepted <= !rst_n ? '0 : accepted + CNTW'(push);
    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wp, rp;
        logic [2:0]       cnt;
        logic             pu, po;
        assign pu = push && in_sel == 2'(i);
        assign po = out_valid[i] && out_ready[i];
        assign full[i] = cnt == FULL;
        assign out_valid[i] = cnt != '0;
        assign out_data[i*WIDTH +: WIDTH] = out_valid[i] ? mem[rp] : '0;
        assign out_count[i*3 +: 3] = cnt;
        // Storage is deliberately left out of reset; the pointers alone define contents.
        always_ff @(posedge clk)
            if (rst_n && pu) mem[wp] <= in_data;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wp + AW'(pu);
                rp  <= rp + AW'(po);
                cnt <= cnt + 3'(pu) - 3'(po);
            end
        end
    end
endmodule

// File: tb/tb_demux4_5bits_fifo.sv
// tb_demux4_5bits_fifo: directed and randomized checks against a queue-based channel model
module tb_demux4_5bits_fifo;
    localparam int W = 5, D = 2;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready;
    logic [W-1:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic [3:0]  out_valid, out_ready = '0;
    logic [4*W-1:0] out_data;
    logic [11:0] out_count;
    logic [7:0]  accepted;
    int n_chk = 0, n_fail = 0;
    logic [W-1:0] q [4][$];
    logic [7:0]  m_acc = '0;

    demux4_5bits_fifo #(.WIDTH(W), .DEPTH(D), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .accepted(accepted));

    always #5 clk = ~clk;

    function automatic logic [3:0] m_valid();
        for (int i = 0; i < 4; i++) m_valid[i] = q[i].size() != 0;
    endfunction
    function automatic logic [4*W-1:0] m_data();
        m_data = '0;
        for (int i = 0; i < 4; i++) if (q[i].size() != 0) m_data[i*W +: W] = q[i][0];
    endfunction
    function automatic logic [11:0] m_count();
        for (int i = 0; i < 4; i++) m_count[i*3 +: 3] = 3'(q[i].size());
    endfunction
    function automatic logic m_ready();
        return q[in_sel].size() != D;
    endfunction

    // Advance one edge, applying the channel rules to the model alongside the DUT.
    task automatic tick();
        bit acc;
        logic [3:0] pop;
        acc = in_valid && q[in_sel].size() < D;
        pop = out_ready & m_valid();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            m_acc = '0;
        end else begin
            for (int i = 0; i < 4; i++) if (pop[i]) void'(q[i].pop_front());
            if (acc) begin
                q[in_sel].push_back(in_data);
                m_acc++;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [3:0] r);
        in_valid = v; in_sel = s; in_data = d; out_ready = r;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst_n = 0; tick(); rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
        n_chk++; if (out_count !== 12'd0) begin n_fail++; $display("FAIL reset_count: got %h want 000", out_count); end
        n_chk++; if (accepted !== 8'd0) begin n_fail++; $display("FAIL reset_acc: got %0d want 0", accepted); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    endtask

    task automatic test_fill_all();
        logic [W-1:0] v [4] = '{5'd8, 5'd6, 5'd4, 5'd2};
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(1, 2'(i), v[i], 0); tick(); end
        drive(0, 0, 0, 0);
        n_chk++; if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL fill_valid: got %b want 1111", out_valid); end
        n_chk++; if (out_data !== {5'd2, 5'd4, 5'd6, 5'd8}) begin n_fail++; $display("FAIL fill_data: got %h want %h", out_data, {5'd2, 5'd4, 5'd6, 5'd8}); end
        n_chk++; if (out_count !== {4{3'd1}}) begin n_fail++; $display("FAIL fill_count: got %h want 249", out_count); end
        n_chk++; if (accepted !== 8'd4) begin n_fail++; $display("FAIL fill_acc: got %0d want 4", accepted); end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_rdy [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0] v [3] = '{5'd3, 5'd7, 5'd9};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b01, v[i], 0);
            n_chk++; if (in_ready !== exp_rdy[i][0]) begin n_fail++; $display("FAIL bp_ready%0d: got %b want %b", i, in_ready, exp_rdy[i][0]); end
            tick();
        end
        n_chk++; if (out_count[5:3] !== 3'd2 || accepted !== 8'd2) begin n_fail++; $display("FAIL bp_full: got count %0d acc %0d want 2 2", out_count[5:3], accepted); end
        drive(1, 2'b01, 5'd9, 4'b0010);
        tick();
        drive(1, 2'b01, 5'd9, 4'b0000);
        n_chk++; if (out_data[9:5] !== 5'd7 || out_count[5:3] !== 3'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_pop: got head %0d count %0d rdy %b want 7 1 1", out_data[9:5], out_count[5:3], in_ready); end
        tick();
        drive(0, 0, 0, 0);
        n_chk++; if (out_count[5:3] !== 3'd2 || accepted !== 8'd3 || out_data[9:5] !== 5'd7) begin n_fail++; $display("FAIL bp_late: got count %0d acc %0d head %0d want 2 3 7", out_count[5:3], accepted, out_data[9:5]); end
    endtask

    task automatic test_full_pop();
        do_reset();
        drive(1, 2'b10, 5'd1, 0); tick();
        drive(1, 2'b10, 5'd2, 0); tick();
        drive(1, 2'b10, 5'd5, 4'b0100);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fp_nobypass: got %b want 0", in_ready); end
        tick();
        drive(1, 2'b10, 5'd5, 0);
        n_chk++; if (in_ready !== 1'b1 || out_data[14:10] !== 5'd2) begin n_fail++; $display("FAIL fp_after: got rdy %b head %0d want 1 2", in_ready, out_data[14:10]); end
        tick();
        drive(0, 0, 0, 4'b0100);
        n_chk++; if (out_data[14:10] !== 5'd2 || out_count[8:6] !== 3'd2) begin n_fail++; $display("FAIL fp_drain1: got %0d/%0d want 2/2", out_data[14:10], out_count[8:6]); end
        tick();
        n_chk++; if (out_data[14:10] !== 5'd5) begin n_fail++; $display("FAIL fp_drain2: got %0d want 5", out_data[14:10]); end
        tick();
        n_chk++; if (out_valid[2] !== 1'b0 || out_data[14:10] !== 5'd0) begin n_fail++; $display("FAIL fp_empty: got v%b d%0d want v0 d0", out_valid[2], out_data[14:10]); end
    endtask

    task automatic test_latency();
        do_reset();
        drive(1, 2'b11, 5'd17, 4'b1000);
        n_chk++; if (out_valid[3] !== 1'b0 || out_data[19:15] !== 5'd0) begin n_fail++; $display("FAIL lat_bypass: got v%b d%0d want v0 d0", out_valid[3], out_data[19:15]); end
        tick();
        drive(0, 0, 0, 4'b1000);
        n_chk++; if (out_valid[3] !== 1'b1 || out_data[19:15] !== 5'd17) begin n_fail++; $display("FAIL lat_head: got v%b d%0d want v1 d17", out_valid[3], out_data[19:15]); end
        tick();
        n_chk++; if (out_valid[3] !== 1'b0 || out_data[19:15] !== 5'd0 || out_count[11:9] !== 3'd0) begin n_fail++; $display("FAIL lat_pop: got v%b d%0d c%0d want 0 0 0", out_valid[3], out_data[19:15], out_count[11:9]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(1, 2'(i % 4), 5'(20 + i), 0); tick(); end
        n_chk++; if (out_count !== {4{3'd2}}) begin n_fail++; $display("FAIL rm_full: got %h want %h", out_count, {4{3'd2}}); end
        drive(1, 0, 5'd30, 4'b1111);
        rst_n = 0; tick(); rst_n = 1;
        drive(0, 0, 0, 0);
        n_chk++; if (out_valid !== 4'b0 || out_count !== 12'd0 || accepted !== 8'd0) begin n_fail++; $display("FAIL rm_clear: got v%b c%h a%0d want 0 0 0", out_valid, out_count, accepted); end
        drive(1, 0, 5'd12, 0); tick();
        drive(0, 0, 0, 0);
        n_chk++; if (out_data !== 20'd12 || out_count !== 12'd1) begin n_fail++; $display("FAIL rm_push: got d%h c%h want 0000c 001", out_data, out_count); end
    endtask

    task automatic test_stream();
        logic [W-1:0] sent [4][$];
        int got [4];
        do_reset();
        for (int i = 0; i < 4; i++) got[i] = 0;
        for (int k = 0; k < 264; k++) begin
            logic [W-1:0] d = W'($urandom);
            drive(k < 260, 2'(k % 4), d, 4'b1111);
            for (int c = 0; c < 4; c++) if (out_valid[c]) begin
                n_chk++;
                if (got[c] >= sent[c].size() || out_data[c*W +: W] !== sent[c][got[c]]) begin n_fail++; $display("FAIL stream_ch%0d_%0d: got %0d want ordered input", c, got[c], out_data[c*W +: W]); end
                got[c]++;
            end
            if (k < 260 && in_ready) sent[k % 4].push_back(d);
            tick();
        end
        drive(0, 0, 0, 0);
        n_chk++; if (accepted !== 8'd4) begin n_fail++; $display("FAIL stream_wrap: got %0d want 4", accepted); end
        for (int c = 0; c < 4; c++) begin
            n_chk++; if (got[c] != 65 || sent[c].size() != 65) begin n_fail++; $display("FAIL stream_cnt%0d: got %0d/%0d want 65", c, got[c], sent[c].size()); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), 4'($urandom));
            rst_n = $urandom_range(0, 60) != 0;
            n_chk++; if (in_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", k, in_ready, m_ready()); end
            tick();
            rst_n = 1;
            n_chk++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", k, out_valid, m_valid()); end
            n_chk++; if (out_data !== m_data()) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", k, out_data, m_data()); end
            n_chk++; if (out_count !== m_count()) begin n_fail++; $display("FAIL rnd_count@%0d: got %h want %h", k, out_count, m_count()); end
            n_chk++; if (accepted !== m_acc) begin n_fail++; $display("FAIL rnd_acc@%0d: got %0d want %0d", k, accepted, m_acc); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_all();
        test_backpressure();
        test_full_pop();
        test_latency();
        test_reset_mid();
        test_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
